// File: rtl/demux_route_1to2.sv
`default_nettype none
// ============================================================================
// Module   : demux_route_1to2
// Brief    : Registered 1-to-2 stream demux; port 0 decodes (x<<SHIFT)+1.
// Revision : 1.0
// ============================================================================
module demux_route_1to2 #(
    parameter int WIDTH = 8,
    parameter int SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    input  logic             err_clr,
    output logic [7:0]       err_cnt
);

    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_FULL  = 1'b1;
    localparam logic [7:0] c_ERR_MAX = 8'hFF;

    logic [0:0]       r_state0, r_state1;
    logic [0:0]       w_next0, w_next1;
    logic [WIDTH-1:0] r_data0, r_data1;
    logic [7:0]       r_err;
    logic             w_free0, w_free1;
    logic             w_acc0, w_acc1;
    logic             w_drain0, w_drain1;
    logic [WIDTH-1:0] w_minus1;
    logic [WIDTH-1:0] w_dec;
    logic             w_malformed;

    // A full slot is still free when its consumer drains it this cycle.
    assign w_free0  = (r_state0 == c_EMPTY) || out0_ready;
    assign w_free1  = (r_state1 == c_EMPTY) || out1_ready;
    assign in_ready = in_sel ? w_free1 : w_free0;

    assign w_acc0   = in_valid && in_ready && !in_sel;
    assign w_acc1   = in_valid && in_ready &&  in_sel;
    assign w_drain0 = (r_state0 == c_FULL) && out0_ready;
    assign w_drain1 = (r_state1 == c_FULL) && out1_ready;

    assign w_minus1    = in_data - {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_dec       = w_minus1 >> SHIFT;
    assign w_malformed = (in_data[SHIFT-1:0] != SHIFT'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state0 <= c_EMPTY;
            r_state1 <= c_EMPTY;
        end else begin
            r_state0 <= w_next0;
            r_state1 <= w_next1;
        end
    end

    always_comb begin
        w_next0 = r_state0;
        case (r_state0)
            c_EMPTY: if (w_acc0) w_next0 = c_FULL;
            c_FULL:  if (!w_acc0 && w_drain0) w_next0 = c_EMPTY;
            default: w_next0 = c_EMPTY;
        endcase
    end

    always_comb begin
        w_next1 = r_state1;
        case (r_state1)
            c_EMPTY: if (w_acc1) w_next1 = c_FULL;
            c_FULL:  if (!w_acc1 && w_drain1) w_next1 = c_EMPTY;
            default: w_next1 = c_EMPTY;
        endcase
    end

    always_comb begin
        out0_valid = (r_state0 == c_FULL);
        out1_valid = (r_state1 == c_FULL);
        out0_data  = r_data0;
        out1_data  = r_data1;
        err_cnt    = r_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data0 <= '0;
            r_data1 <= '0;
        end else begin
            if (w_acc0) r_data0 <= w_dec;
            if (w_acc1) r_data1 <= in_data;
        end
    end

    // Clear takes priority over a same-cycle malformed accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 8'h00;
        end else if (err_clr) begin
            r_err <= 8'h00;
        end else if (w_acc0 && w_malformed && (r_err != c_ERR_MAX)) begin
            r_err <= r_err + 8'h01;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_route_1to2.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_route_1to2
// Brief    : Scoreboard bench for demux_route_1to2 (WIDTH=8, SHIFT=2).
// Revision : 1.0
// ============================================================================
module tb_demux_route_1to2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_sel = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out0_valid, out1_valid;
    logic       out0_ready = 1'b1;
    logic       out1_ready = 1'b1;
    logic [7:0] out0_data, out1_data;
    logic       err_clr = 1'b0;
    logic [7:0] err_cnt;

    int n_vec  = 0;
    int n_fail = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    demux_route_1to2 #(.WIDTH(8), .SHIFT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
        .err_clr(err_clr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for one cycle; exp_rdy says whether it must be taken.
    task automatic send(input logic sel, input logic [7:0] d, input logic [7:0] exp_d,
                        input logic exp_rdy);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        #1;
        check("in_ready", in_ready, exp_rdy);
        if (in_ready) begin
            if (sel) q1.push_back(exp_d);
            else     q0.push_back(exp_d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: compare every output transfer against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out0_valid && out0_ready) begin
                if (q0.size() == 0) check("out0_unexpected", out0_data, 32'hDEAD);
                else check("out0_data", out0_data, q0.pop_front());
            end
            if (out1_valid && out1_ready) begin
                if (q1.size() == 0) check("out1_unexpected", out1_data, 32'hDEAD);
                else check("out1_data", out1_data, q1.pop_front());
            end
        end
    end

    initial begin
        #2;
        check("rst_out0_valid", out0_valid, 0);
        check("rst_out1_valid", out1_valid, 0);
        check("rst_out0_data", out0_data, 0);
        check("rst_out1_data", out1_data, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;

        // Decode path
        send(1'b0, 8'h0D, 8'h03, 1'b1);
        check("dec_out0_valid", out0_valid, 1);
        check("dec_out1_valid", out1_valid, 0);
        check("dec_err_cnt", err_cnt, 0);

        // Alternating stream, no bubbles
        send(1'b1, 8'hA5, 8'hA5, 1'b1);
        send(1'b0, 8'h11, 8'h04, 1'b1);
        send(1'b1, 8'hFF, 8'hFF, 1'b1);
        send(1'b0, 8'h05, 8'h01, 1'b1);
        tick();

        // Backpressure on port 1 must not block port 0
        out1_ready = 1'b0;
        send(1'b1, 8'h22, 8'h22, 1'b1);
        send(1'b1, 8'h33, 8'h33, 1'b0);
        check("bp_out1_hold", out1_data, 8'h22);
        check("bp_out1_valid", out1_valid, 1);
        send(1'b0, 8'h09, 8'h02, 1'b1);
        check("bp_out0_data", out0_data, 8'h02);
        out1_ready = 1'b1;
        send(1'b1, 8'h33, 8'h33, 1'b1);
        check("bp_refill", out1_data, 8'h33);
        tick();

        // Malformed words and saturation
        send(1'b0, 8'h0E, 8'h03, 1'b1);
        check("mal_err_1", err_cnt, 1);
        for (int i = 0; i < 300; i++) send(1'b0, 8'h02, 8'h00, 1'b1);
        check("mal_err_sat", err_cnt, 8'hFF);
        err_clr = 1'b1;
        send(1'b0, 8'h0E, 8'h03, 1'b1);
        err_clr = 1'b0;
        check("mal_err_clr", err_cnt, 0);
        tick();

        // Reset mid-operation with both slots stalled
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(1'b0, 8'h0F, 8'h03, 1'b1);
        send(1'b1, 8'h5A, 8'h5A, 1'b1);
        check("pre_rst_out0", out0_data, 8'h03);
        check("pre_rst_out1", out1_data, 8'h5A);
        check("pre_rst_err", err_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out0_valid", out0_valid, 0);
        check("mid_rst_out1_valid", out1_valid, 0);
        check("mid_rst_err", err_cnt, 0);
        check("mid_rst_in_ready", in_ready, 1);
        q0.delete();
        q1.delete();
        tick();
        rst_n = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        send(1'b0, 8'h0D, 8'h03, 1'b1);
        check("post_rst_out0_valid", out0_valid, 1);
        check("post_rst_out0_data", out0_data, 8'h03);
        tick();
        tick();
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
